sequential_unary_nand: RTL and testbench

// - Multi-cycle N-bit unary NAND reduction (c = ~&a). Used where N is too wide to close timing as a single-cycle reduction.
// - Sits downstream of the operand registers and upstream of the result consumer.
// - Input and output use valid/ready handshakes.
// - Processes W bits per cycle; one operand in flight at a time.
//

---
 rtl/sequential_unary_nand.sv | 114 +++++++++++
 tb/tb_sequential_unary_nand.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_unary_nand.sv
// Multi-cycle N-bit NAND reduction (out_c = ~&in_a), W bits per cycle, valid/ready on both sides.
// Optional early termination on the first chunk containing a zero: SEQUENTIAL_UNARY_NAND_EARLY_EXIT_EN.
module sequential_unary_nand #(
    parameter int unsigned N = 64,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_c,
    output logic         busy
);

    localparam int unsigned K  = (N + W - 1) / W;
    localparam int unsigned PW = K * W;
    localparam int unsigned CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic            out_c_q, out_c_d;

    logic [PW-1:0]   op_ext;
    logic            chunk_all1;
    logic            last_chunk;
    logic            finish;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
        end
    end

    // Operand is shifted right one chunk per RUN edge, so the current chunk is always the low W bits.
    always_comb begin
        op_ext         = '1;
        op_ext[N-1:0]  = in_a;
        chunk_all1     = &op_q[W-1:0];
        last_chunk     = (cnt_q == CW'(K - 1));
`ifdef SEQUENTIAL_UNARY_NAND_EARLY_EXIT_EN
        finish         = last_chunk || !chunk_all1;
`else
        finish         = last_chunk;
`endif

        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_ext;
                    acc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q & chunk_all1;
                cnt_d = cnt_q + CW'(1);
                op_d  = op_q >> W;
                if (finish) begin
                    out_c_d     = ~(acc_q & chunk_all1);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;

endmodule

// File: tb/tb_sequential_unary_nand.sv
// Scoreboard bench for sequential_unary_nand: N=16/W=4 main instance plus N=10/W=4 padding instance.
module tb_sequential_unary_nand;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        v16, ir16, ov16, or16, c16, b16;
    logic [15:0] a16;
    logic        v10, ir10, ov10, or10, c10, b10;
    logic [9:0]  a10;

    int tests = 0;
    int fails = 0;
    bit exp_q[$];

    sequential_unary_nand #(.N(16), .W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .in_a(a16),
        .out_valid(ov16), .out_ready(or16), .out_c(c16), .busy(b16)
    );

    sequential_unary_nand #(.N(10), .W(4)) dut10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_ready(ir10), .in_a(a10),
        .out_valid(ov10), .out_ready(or10), .out_c(c10), .busy(b10)
    );

    // Expected edges from accept to out_valid, from the chunking rule with 1-padding.
    function automatic int exp_lat(input logic [15:0] a, input int n);
        int k;
        logic [3:0] ch;
        k = (n + 3) / 4;
`ifdef SEQUENTIAL_UNARY_NAND_EARLY_EXIT_EN
        for (int i = 0; i < k; i++) begin
            ch = 4'hF;
            for (int b = 0; b < 4; b++)
                if (i * 4 + b < n) ch[b] = a[i * 4 + b];
            if (ch != 4'hF) return i + 1;
        end
`else
        ch = 4'hF;
        if (ch != 4'hF) return 0;
`endif
        return k;
    endfunction

    task automatic op16(input logic [15:0] a, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!ir16 && t < 50) begin @(negedge clk); t++; end
        if (!ir16) begin
            tests++; fails++;
            $display("FAIL op16_in_ready_timeout: in_ready=%b required 1", ir16);
        end
        v16 = 1'b1; a16 = a;
        exp_q.push_back(~&a);
        @(negedge clk);
        v16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic op10(input logic [9:0] a, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!ir10 && t < 50) begin @(negedge clk); t++; end
        if (!ir10) begin
            tests++; fails++;
            $display("FAIL op10_in_ready_timeout: in_ready=%b required 1", ir10);
        end
        v10 = 1'b1; a10 = a;
        exp_q.push_back(~&a);
        @(negedge clk);
        v10 = 1'b0;
        lat = 0;
        while (!ov10 && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic pop_exp(output bit e);
        e = 1'b0;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: result seen with no expected entry");
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v16 = 0; v10 = 0; a16 = '0; a10 = '0; or16 = 1; or10 = 1;
        #12;
        tests++;
        if ({ov16, c16, b16, ir16} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state: ov/c/busy/in_ready=%b required 0000", {ov16, c16, b16, ir16});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ir16, ir10, b16, b10} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_release: ir16/ir10/b16/b10=%b required 1100", {ir16, ir10, b16, b10});
        end
    endtask

    task automatic test_all_ones();
        int lat; bit e;
        op16(16'hFFFF, lat);
        pop_exp(e);
        tests++;
        if (lat !== 4 || ov16 !== 1'b1 || c16 !== e) begin
            fails++;
            $display("FAIL all_ones: lat=%0d ov=%b c=%b required lat=4 ov=1 c=%b", lat, ov16, c16, e);
        end
        @(negedge clk);
        tests++;
        if ({ov16, b16, ir16} !== 3'b001) begin
            fails++;
            $display("FAIL all_ones_idle: ov/busy/in_ready=%b required 001", {ov16, b16, ir16});
        end
    endtask

    task automatic test_patterns();
        logic [15:0] pats [3];
        int lat; bit e;
        pats[0] = 16'hFFFE; pats[1] = 16'h0FFF; pats[2] = 16'hFF0F;
        for (int i = 0; i < 3; i++) begin
            op16(pats[i], lat);
            pop_exp(e);
            tests++;
            if (lat !== exp_lat(pats[i], 16) || c16 !== e || e !== 1'b1) begin
                fails++;
                $display("FAIL pattern_%h: lat=%0d c=%b required lat=%0d c=%b",
                         pats[i], lat, c16, exp_lat(pats[i], 16), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_padding();
        logic [9:0] pats [2];
        int lat; bit e;
        pats[0] = 10'h3FF; pats[1] = 10'h1FF;
        for (int i = 0; i < 2; i++) begin
            op10(pats[i], lat);
            pop_exp(e);
            tests++;
            if (lat !== 3 || c10 !== e) begin
                fails++;
                $display("FAIL padding_%h: lat=%0d c=%b required lat=3 c=%b", pats[i], lat, c10, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit e;
        or16 = 1'b0;
        op16(16'hFFFF, lat);
        pop_exp(e);
        for (int i = 0; i < 6; i++) begin
            v16 = 1'b1; a16 = 16'h0000;
            @(negedge clk);
            tests++;
            if ({ov16, c16, ir16} !== {1'b1, e, 1'b0}) begin
                fails++;
                $display("FAIL hold_cycle_%0d: ov/c/in_ready=%b required %b", i, {ov16, c16, ir16}, {1'b1, e, 1'b0});
            end
        end
        v16 = 1'b0; or16 = 1'b1;
        @(negedge clk);
        tests++;
        if ({ov16, b16} !== 2'b00) begin
            fails++;
            $display("FAIL hold_release: ov/busy=%b required 00", {ov16, b16});
        end
        op16(16'h0000, lat);
        pop_exp(e);
        tests++;
        if (lat !== exp_lat(16'h0000, 16) || c16 !== e) begin
            fails++;
            $display("FAIL zero_after_hold: lat=%0d c=%b required lat=%0d c=%b", lat, c16, exp_lat(16'h0000, 16), e);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat; bit e;
        @(negedge clk);
        v16 = 1'b1; a16 = 16'hFFFF;
        @(negedge clk);
        v16 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({ov16, c16, b16, ir16} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: ov/c/busy/in_ready=%b required 0000", {ov16, c16, b16, ir16});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ov16, b16, ir16} !== 3'b001) begin
            fails++;
            $display("FAIL reset_drop: ov/busy/in_ready=%b required 001", {ov16, b16, ir16});
        end
        op16(16'hFFFF, lat);
        pop_exp(e);
        tests++;
        if (lat !== 4 || c16 !== e) begin
            fails++;
            $display("FAIL after_reset: lat=%0d c=%b required lat=4 c=%b", lat, c16, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int got = 0;
        bit drv_done = 0;
        fork
            begin
                int t;
                logic [15:0] a;
                for (int i = 0; i < 1000; i++) begin
                    a = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) a = 16'hFFFF;
                    @(negedge clk);
                    t = 0;
                    while (!ir16 && t < 200) begin @(negedge clk); t++; end
                    if (!ir16) begin
                        tests++; fails++;
                        $display("FAIL b2b_in_ready_timeout: iteration %0d", i);
                        break;
                    end
                    v16 = 1'b1; a16 = a;
                    exp_q.push_back(~&a);
                    @(negedge clk);
                    v16 = 1'b0;
                end
                drv_done = 1;
            end
            begin
                int cyc = 0;
                bit e;
                bit held = 0;
                logic held_c = 1'b0;
                while (got < 1000 && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    if (held) begin
                        tests++;
                        if (ov16 !== 1'b1 || c16 !== held_c) begin
                            fails++;
                            $display("FAIL b2b_hold: ov=%b c=%b required ov=1 c=%b", ov16, c16, held_c);
                        end
                    end
                    or16 = 1'($urandom_range(0, 1));
                    held = ov16 && !or16;
                    held_c = c16;
                    if (ov16 && or16) begin
                        pop_exp(e);
                        tests++;
                        if (c16 !== e) begin
                            fails++;
                            $display("FAIL b2b_result_%0d: c=%b required %b", got, c16, e);
                        end
                        got++;
                    end
                end
                @(negedge clk);
                or16 = 1'b1;
            end
        join
        tests++;
        if (got !== 1000 || exp_q.size() !== 0 || !drv_done) begin
            fails++;
            $display("FAIL b2b_count: got=%0d pending=%0d required got=1000 pending=0", got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_padding();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
